// File: rtl/eeprom_access_arbiter.sv
// Two-requester round-robin front end for EEPROM_CTRL: latches the winning command,
// drives RD/WR/ADDR/DATA, waits for the matching END (with timeout) and reports DONE/ERR.
module eeprom_access_arbiter #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int ADDR_W      = 11
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_0,
    input  logic              WE_0,
    input  logic [ADDR_W-1:0] ADDR_0,
    input  logic [7:0]        WDATA_0,
    output logic              GNT_0,
    output logic              DONE_0,
    input  logic              REQ_1,
    input  logic              WE_1,
    input  logic [ADDR_W-1:0] ADDR_1,
    input  logic [7:0]        WDATA_1,
    output logic              GNT_1,
    output logic              DONE_1,
    output logic [7:0]        RDATA,
    output logic              ERR,
    output logic              RD,
    output logic              WR,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [7:0]        DATA,
    input  logic              RD_END,
    input  logic              WR_END
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_END = 3'd2,
        S_DONE     = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t            state, state_next;
    logic              last, last_next;          // requester served most recently
    logic              owner, owner_next;        // requester owning the current access
    logic              we_lat, we_next;
    logic [ADDR_W-1:0] addr_lat, addr_lat_next;
    logic [7:0]        wdata_lat, wdata_next;
    logic              rd, rd_next;
    logic              wr, wr_next;
    logic [ADDR_W-1:0] addr_out, addr_out_next;
    logic              drive, drive_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              timed_out, timed_out_next;
    logic [7:0]        rdata, rdata_next;
    logic              gnt0, gnt0_next;
    logic              gnt1, gnt1_next;
    logic              done0, done0_next;
    logic              done1, done1_next;
    logic              err, err_next;
    logic              pick1;
    logic              end_hit;

    assign DATA   = drive ? wdata_lat : 8'hzz;
    assign RD     = rd;
    assign WR     = wr;
    assign ADDR   = addr_out;
    assign RDATA  = rdata;
    assign ERR    = err;
    assign GNT_0  = gnt0;
    assign GNT_1  = gnt1;
    assign DONE_0 = done0;
    assign DONE_1 = done1;

    // State and registered-output update; reset drops strobes and releases DATA at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            we_lat    <= 1'b0;
            addr_lat  <= {ADDR_W{1'b0}};
            wdata_lat <= 8'h00;
            rd        <= 1'b0;
            wr        <= 1'b0;
            addr_out  <= {ADDR_W{1'b0}};
            drive     <= 1'b0;
            cnt       <= {CNT_W{1'b0}};
            timed_out <= 1'b0;
            rdata     <= 8'h00;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            owner     <= owner_next;
            we_lat    <= we_next;
            addr_lat  <= addr_lat_next;
            wdata_lat <= wdata_next;
            rd        <= rd_next;
            wr        <= wr_next;
            addr_out  <= addr_out_next;
            drive     <= drive_next;
            cnt       <= cnt_next;
            timed_out <= timed_out_next;
            rdata     <= rdata_next;
            gnt0      <= gnt0_next;
            gnt1      <= gnt1_next;
            done0     <= done0_next;
            done1     <= done1_next;
            err       <= err_next;
        end
    end

    // Next-state and next-output logic for the access sequence.
    always_comb begin
        state_next     = state;
        last_next      = last;
        owner_next     = owner;
        we_next        = we_lat;
        addr_lat_next  = addr_lat;
        wdata_next     = wdata_lat;
        rd_next        = rd;
        wr_next        = wr;
        addr_out_next  = addr_out;
        drive_next     = drive;
        cnt_next       = cnt;
        timed_out_next = timed_out;
        rdata_next     = rdata;
        gnt0_next      = 1'b0;
        gnt1_next      = 1'b0;
        done0_next     = 1'b0;
        done1_next     = 1'b0;
        err_next       = 1'b0;
        // Requester 1 wins when alone, or on a tie when requester 0 was served last.
        pick1          = REQ_1 && (!REQ_0 || !last);
        end_hit        = we_lat ? WR_END : RD_END;

        case (state)
            S_IDLE: begin
                if (REQ_0 || REQ_1) begin
                    owner_next    = pick1;
                    last_next     = pick1;
                    we_next       = pick1 ? WE_1 : WE_0;
                    addr_lat_next = pick1 ? ADDR_1 : ADDR_0;
                    wdata_next    = pick1 ? WDATA_1 : WDATA_0;
                    gnt0_next     = !pick1;
                    gnt1_next     = pick1;
                    state_next    = S_ISSUE;
                end else begin
                    state_next    = S_IDLE;
                end
            end
            S_ISSUE: begin
                rd_next        = !we_lat;
                wr_next        = we_lat;
                addr_out_next  = addr_lat;
                drive_next     = we_lat;
                cnt_next       = {CNT_W{1'b0}};
                timed_out_next = 1'b0;
                state_next     = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (end_hit) begin
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    drive_next = 1'b0;
                    if (!we_lat) begin
                        rdata_next = DATA;
                    end else begin
                        rdata_next = rdata;
                    end
                    done0_next = !owner;
                    done1_next = owner;
                    state_next = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    rd_next        = 1'b0;
                    wr_next        = 1'b0;
                    drive_next     = 1'b0;
                    timed_out_next = 1'b1;
                    err_next       = 1'b1;
                    done0_next     = !owner;
                    done1_next     = owner;
                    state_next     = S_DONE;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                    state_next = S_WAIT_END;
                end
            end
            S_DONE: begin
                state_next = S_RELEASE;
            end
            S_RELEASE: begin
                // A still-high END from the finished access must not satisfy the next one.
                if (timed_out || (!RD_END && !WR_END)) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_RELEASE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Directed plus randomized bench for eeprom_access_arbiter; expected grant order, timing
// and read data come from a transaction-level model of the arbitration rules.
module tb_eeprom_access_arbiter;

    localparam int TO = 24;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        REQ_0 = 1'b0, WE_0 = 1'b0, REQ_1 = 1'b0, WE_1 = 1'b0;
    logic [10:0] ADDR_0 = 11'd0, ADDR_1 = 11'd0;
    logic [7:0]  WDATA_0 = 8'd0, WDATA_1 = 8'd0;
    logic        GNT_0, DONE_0, GNT_1, DONE_1, ERR, RD, WR;
    logic [7:0]  RDATA;
    logic [10:0] ADDR;
    wire  [7:0]  DATA;
    logic        RD_END = 1'b0, WR_END = 1'b0;
    logic        tb_drv_en = 1'b0;
    logic [7:0]  tb_drv = 8'h00;

    int          vectors = 0;
    int          miscompares = 0;
    int          last_served = 1;
    logic [7:0]  rdata_exp = 8'h00;

    assign DATA = tb_drv_en ? tb_drv : 8'hzz;

    eeprom_access_arbiter #(.TIMEOUT_CYC(TO), .ADDR_W(11)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_0(REQ_0), .WE_0(WE_0), .ADDR_0(ADDR_0), .WDATA_0(WDATA_0), .GNT_0(GNT_0), .DONE_0(DONE_0),
        .REQ_1(REQ_1), .WE_1(WE_1), .ADDR_1(ADDR_1), .WDATA_1(WDATA_1), .GNT_1(GNT_1), .DONE_1(DONE_1),
        .RDATA(RDATA), .ERR(ERR), .RD(RD), .WR(WR), .ADDR(ADDR), .DATA(DATA),
        .RD_END(RD_END), .WR_END(WR_END)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Released bus reads as Z in 4-state simulators and 0 in 2-state ones.
    function automatic logic [31:0] data_released();
        return 32'((DATA === 8'hzz) || (DATA === 8'h00));
    endfunction

    task automatic new_fields(input int who);
        if (who == 1) begin
            REQ_1 = 1'b1; WE_1 = 1'($urandom_range(0, 1));
            ADDR_1 = 11'($urandom); WDATA_1 = 8'($urandom_range(1, 255));
        end else begin
            REQ_0 = 1'b1; WE_0 = 1'($urandom_range(0, 1));
            ADDR_0 = 11'($urandom); WDATA_0 = 8'($urandom_range(1, 255));
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        chk("rst_strobes", 32'({RD, WR}), 32'd0);
        chk("rst_data", data_released(), 32'd1);
        chk("rst_outs", 32'({GNT_1, GNT_0, DONE_1, DONE_0, ERR}), 32'd0);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_rdata", 32'(RDATA), 32'd0);
        step();
        RESET = 1'b0;
        last_served = 1;
        rdata_exp = 8'h00;
    endtask

    // One complete access: lat = cycles of strobe before END, to_exp = END never comes.
    task automatic serve(input int lat, input bit to_exp, input int linger, input bit keep);
        int who;
        int n;
        logic we;
        logic [10:0] a;
        logic [7:0] wd;
        logic [7:0] rv;
        who = (REQ_1 && (!REQ_0 || last_served == 0)) ? 1 : 0;
        we  = (who == 1) ? WE_1 : WE_0;
        a   = (who == 1) ? ADDR_1 : ADDR_0;
        wd  = (who == 1) ? WDATA_1 : WDATA_0;
        rv  = 8'($urandom);
        for (int i = 0; i < 20 && !(GNT_0 || GNT_1); i++) step();
        chk("gnt_seen", 32'(GNT_0 | GNT_1), 32'd1);
        chk("gnt_who", 32'({GNT_1, GNT_0}), (who == 1) ? 32'd2 : 32'd1);
        last_served = who;
        if (keep) new_fields(who);
        else if (who == 1) REQ_1 = 1'b0;
        else REQ_0 = 1'b0;
        step();
        chk("gnt_pulse", 32'({GNT_1, GNT_0}), 32'd0);
        n = to_exp ? TO : lat + 1;
        for (int i = 0; i < n; i++) begin
            chk("strobe", 32'({RD, WR}), we ? 32'd1 : 32'd2);
            chk("addr", 32'(ADDR), 32'(a));
            if (we) chk("wdata_drv", 32'(DATA), 32'(wd));
            else chk("rd_bus_rel", data_released(), 32'd1);
            chk("done_early", 32'({DONE_1, DONE_0}), 32'd0);
            if (!to_exp && i == n - 1) begin
                if (we) WR_END = 1'b1;
                else begin RD_END = 1'b1; tb_drv = rv; tb_drv_en = 1'b1; end
            end
            step();
        end
        tb_drv_en = 1'b0;
        #1;
        chk("strobe_off", 32'({RD, WR}), 32'd0);
        chk("data_rel", data_released(), 32'd1);
        chk("done", 32'({DONE_1, DONE_0}), (who == 1) ? 32'd2 : 32'd1);
        chk("err", 32'(ERR), 32'(to_exp));
        chk("gnt_at_done", 32'({GNT_1, GNT_0}), 32'd0);
        if (!we && !to_exp) rdata_exp = rv;
        chk("rdata", 32'(RDATA), 32'(rdata_exp));
        for (int j = 0; j < linger; j++) begin
            step();
            chk("linger_done", 32'({DONE_1, DONE_0, ERR}), 32'd0);
            chk("linger_gnt", 32'({GNT_1, GNT_0}), 32'd0);
        end
        RD_END = 1'b0;
        WR_END = 1'b0;
        step();
        chk("done_pulse", 32'({DONE_1, DONE_0, ERR}), 32'd0);
        chk("gnt_after_done", 32'({GNT_1, GNT_0}), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Single write of 0xFF to 0x120, END after 20 strobe cycles.
        REQ_0 = 1'b1; WE_0 = 1'b1; ADDR_0 = 11'h120; WDATA_0 = 8'hFF;
        serve(20, 1'b0, 0, 1'b0);

        // Both requesters raised together after reset: strict alternation.
        do_reset();
        new_fields(0);
        new_fields(1);
        for (int k = 0; k < 8; k++) begin
            chk("alt_order", 32'((REQ_1 && (!REQ_0 || last_served == 0)) ? 1 : 0), 32'(k % 2));
            serve($urandom_range(0, 6), 1'b0, $urandom_range(0, 2), k < 6);
        end

        // Read from requester 1 at 0x105 returning 0xA5.
        REQ_1 = 1'b1; WE_1 = 1'b0; ADDR_1 = 11'h105;
        for (int i = 0; i < 20 && !(GNT_0 || GNT_1); i++) step();
        chk("rd_gnt", 32'({GNT_1, GNT_0}), 32'd2);
        REQ_1 = 1'b0;
        last_served = 1;
        step();
        chk("rd_strobe", 32'({RD, WR}), 32'd2);
        chk("rd_addr", 32'(ADDR), 32'h105);
        RD_END = 1'b1; tb_drv = 8'hA5; tb_drv_en = 1'b1;
        step();
        tb_drv_en = 1'b0; RD_END = 1'b0;
        #1;
        chk("rd_done", 32'({DONE_1, DONE_0}), 32'd2);
        chk("rd_rdata", 32'(RDATA), 32'hA5);
        rdata_exp = 8'hA5;
        step();
        step();

        // Write that never sees WR_END: timeout, then a normal access.
        REQ_0 = 1'b1; WE_0 = 1'b1; ADDR_0 = 11'h3C0; WDATA_0 = 8'h5A;
        serve(0, 1'b1, 0, 1'b0);
        REQ_0 = 1'b1; WE_0 = 1'b0; ADDR_0 = 11'h011;
        serve(3, 1'b0, 0, 1'b0);

        // Reset during a write's WAIT_END; requester 0 must win afterwards.
        REQ_0 = 1'b1; WE_0 = 1'b1; ADDR_0 = 11'h222; WDATA_0 = 8'h3C;
        for (int i = 0; i < 20 && !(GNT_0 || GNT_1); i++) step();
        chk("rst_mid_gnt", 32'(GNT_0), 32'd1);
        step();
        chk("rst_mid_wr", 32'({RD, WR}), 32'd1);
        step();
        step();
        #1;
        RESET = 1'b1;
        #1;
        chk("rst_mid_strobe", 32'({RD, WR}), 32'd0);
        chk("rst_mid_data", data_released(), 32'd1);
        chk("rst_mid_done", 32'({DONE_1, DONE_0}), 32'd0);
        REQ_1 = 1'b1; WE_1 = 1'b1; ADDR_1 = 11'h077; WDATA_1 = 8'h81;
        step();
        chk("rst_hold_done", 32'({DONE_1, DONE_0, GNT_1, GNT_0}), 32'd0);
        RESET = 1'b0;
        last_served = 1;
        rdata_exp = 8'h00;
        serve(2, 1'b0, 0, 1'b0);
        serve(1, 1'b0, 0, 1'b0);

        // WR_END lingering 3 cycles after DONE with the other requester pending.
        new_fields(0);
        WE_0 = 1'b1;
        new_fields(1);
        serve(4, 1'b0, 3, 1'b0);
        serve(0, 1'b0, 0, 1'b0);

        // Randomized accesses.
        for (int k = 0; k < 10; k++) begin
            int r;
            r = $urandom_range(1, 3);
            if (r[0] && !REQ_0) new_fields(0);
            if (r[1] && !REQ_1) new_fields(1);
            serve($urandom_range(0, TO - 2), 1'b0, $urandom_range(0, 2), 1'b0);
        end
        if (REQ_0 || REQ_1) serve(1, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
